// File: rtl/pearson_pkg.sv
// Shared definitions for the Pearson hash sequencer.
//   state_e           : sequencer state encoding
//   BYTE_W            : message byte / hash width
//   TBL_DEPTH         : permutation table entries
//   ADDR_W            : table address width
//   HASH_INIT_DEFAULT : default starting hash value
package pearson_pkg;

    localparam int BYTE_W    = 8;
    localparam int TBL_DEPTH = 256;
    localparam int ADDR_W    = $clog2(TBL_DEPTH);

    localparam logic [BYTE_W-1:0] HASH_INIT_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pearson_seq_ctrl.sv
// Pearson hash sequencer and table-RAM port arbiter.
// Walks the external permutation table once per accepted message byte
// (h := T[h ^ c]) and presents the final hash on a held valid/ready output.
// The single RAM port is shared with a table-write requester, which is only
// granted between messages.
//
// Ports:
//   clk_i, reset_ni                     : clock, async active-low reset
//   msg_valid_i/msg_data_i/msg_last_i   : message byte stream in
//   msg_ready_o                         : byte accept
//   hash_valid_o/hash_ready_i           : hash handshake
//   hash_o, msg_len_o                   : final hash and byte count
//   tbl_we_i/tbl_addr_i/tbl_data_i      : table-write request
//   tbl_ready_o                         : table write performed this cycle
//   ram_addr_o/ram_we_o/ram_wdata_o     : RAM port (async read)
//   ram_rdata_i                         : RAM read data for ram_addr_o
//   busy_o                              : not idle
//
// state | meaning
// ------+----------------------------------
// IDLE  | no message; table writes granted
// HASH  | inside a message, h accumulating
// DONE  | hash held for the consumer
module pearson_seq_ctrl
    import pearson_pkg::*;
#(
    parameter logic [BYTE_W-1:0] HASH_INIT = HASH_INIT_DEFAULT,
    parameter int                CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              msg_valid_i,
    input  logic [BYTE_W-1:0] msg_data_i,
    input  logic              msg_last_i,
    output logic              msg_ready_o,
    output logic              hash_valid_o,
    input  logic              hash_ready_i,
    output logic [BYTE_W-1:0] hash_o,
    output logic [CNT_W-1:0]  msg_len_o,
    input  logic              tbl_we_i,
    input  logic [ADDR_W-1:0] tbl_addr_i,
    input  logic [BYTE_W-1:0] tbl_data_i,
    output logic              tbl_ready_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [BYTE_W-1:0] ram_wdata_o,
    input  logic [BYTE_W-1:0] ram_rdata_i,
    output logic              busy_o
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] h_q, h_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            h_q     <= HASH_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        cnt_d        = cnt_q;
        msg_ready_o  = 1'b0;
        tbl_ready_o  = 1'b0;
        hash_valid_o = 1'b0;
        hash_o       = '0;
        msg_len_o    = '0;
        ram_addr_o   = HASH_INIT ^ msg_data_i;
        ram_we_o     = 1'b0;
        ram_wdata_o  = '0;

        unique case (state_q)
            IDLE: begin
                tbl_ready_o = 1'b1;
                msg_ready_o = !tbl_we_i;
                if (tbl_we_i) begin
                    ram_addr_o  = tbl_addr_i;
                    ram_we_o    = 1'b1;
                    ram_wdata_o = tbl_data_i;
                end else if (msg_valid_i) begin
                    // First byte always starts from HASH_INIT, whatever h held.
                    h_d     = ram_rdata_i;
                    cnt_d   = CNT_W'(1);
                    state_d = msg_last_i ? DONE : HASH;
                end
            end
            HASH: begin
                msg_ready_o = 1'b1;
                ram_addr_o  = h_q ^ msg_data_i;
                if (msg_valid_i) begin
                    h_d = ram_rdata_i;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (msg_last_i) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                hash_valid_o = 1'b1;
                hash_o       = h_q;
                msg_len_o    = cnt_q;
                if (hash_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule
